// File: rtl/wallace_reduce8.sv
// Two-stage pipelined 8x8 unsigned multiplier front end: partial-product generation and
// Wallace reduction down to two 16-bit rows for the downstream prefix adder.
// Stage 1 runs reduction levels 1-2 (8->6->4 rows) and stage 2 runs levels 3-4 (4->3->2 rows).
module wallace_reduce8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] row_a,
  output logic [15:0] row_b,
  output logic        busy
);

  typedef struct packed {
    logic [15:0] c;
    logic [15:0] s;
  } csa_t;

  // One level of 3:2 compressors across all 16 columns. Columns where an input is
  // structurally zero collapse to half adders. The carry out of bit 15 is dropped.
  function automatic csa_t csa3(input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = {(x[14:0] & y[14:0]) | (x[14:0] & z[14:0]) | (y[14:0] & z[14:0]), 1'b0};
    return r;
  endfunction

  logic        s1_valid_q;
  logic [15:0] s1_row_q [4];
  logic        s2_valid_q;
  logic [15:0] row_a_q, row_b_q;

  logic        s2_adv, s1_adv;
  logic [15:0] pp [8];
  csa_t        l1_0, l1_1, l2_0, l2_1, l3, l4;

  // Flow control: a stage may load when it is empty or its content moves on this edge.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = rst_n && s1_adv;
  end

  // Stage 1 combinational: partial products, then levels 1 and 2.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      pp[j] = {8'h00, a & {8{b[j]}}} << j;
    end
    l1_0 = csa3(pp[0], pp[1], pp[2]);
    l1_1 = csa3(pp[3], pp[4], pp[5]);
    l2_0 = csa3(l1_0.s, l1_0.c, l1_1.s);
    l2_1 = csa3(l1_1.c, pp[6], pp[7]);
  end

  // Stage 2 combinational: levels 3 and 4 on the registered four rows.
  always_comb begin
    l3 = csa3(s1_row_q[0], s1_row_q[1], s1_row_q[2]);
    l4 = csa3(l3.s, l3.c, s1_row_q[3]);
  end

  // Pipeline registers; S2 loads from S1 and S1 from the operands whenever they advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      row_a_q    <= '0;
      row_b_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        s1_row_q[k] <= '0;
      end
    end else begin
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        row_a_q    <= l4.s;
        row_b_q    <= l4.c;
      end
      if (s1_adv) begin
        s1_valid_q  <= in_valid;
        s1_row_q[0] <= l2_0.s;
        s1_row_q[1] <= l2_0.c;
        s1_row_q[2] <= l2_1.s;
        s1_row_q[3] <= l2_1.c;
      end
    end
  end

  // Output drive.
  always_comb begin
    out_valid = s2_valid_q;
    row_a     = row_a_q;
    row_b     = row_b_q;
    busy      = s1_valid_q || s2_valid_q;
  end

endmodule
